// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Widths here match the defaults used by processor_core.
package mem_arb_pkg;

    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    localparam int IADDR_W_DEF    = 10;
    localparam int DADDR_W_DEF    = 8;
    localparam int DATA_W_DEF     = 8;
    localparam int INSTR_W_DEF    = 16;
    localparam int MEM_LAT_DEF    = 1;
    localparam int STARVE_MAX_DEF = 4;

    // One in-flight access: valid marks a read awaiting data,
    // sel says which requester gets the response.
    typedef struct packed {
        logic valid;
        logic sel;
    } arb_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the arbiter.
// master: core and memory side (drives requests and mem_rdata); slave: arbiter.
interface mem_port_arbiter_if #(
    parameter int IADDR_W = 10,
    parameter int DADDR_W = 8,
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 16
);
    logic               if_req;
    logic [IADDR_W-1:0] if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [INSTR_W-1:0] if_rdata;

    logic               d_req;
    logic               d_we;
    logic [DADDR_W-1:0] d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic               d_gnt;
    logic               d_rvalid;
    logic [DATA_W-1:0]  d_rdata;

    logic               mem_en;
    logic               mem_sel;
    logic [IADDR_W-1:0] mem_addr;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_wdata;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_sel, mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_sel, mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of access tags tracking reads in flight.
// Ports: clk, rst (async, active-high), tag_i (pushed every cycle), tag_o (oldest).
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  arb_tag_t tag_i,
    output arb_tag_t tag_o
);

    arb_tag_t stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one grant per cycle.
// Ports: clk, reset (async, active-high), bus (slave view of mem_port_arbiter_if).
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int IADDR_W    = IADDR_W_DEF,
    parameter int DADDR_W    = DADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int INSTR_W    = INSTR_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_MAX = STARVE_MAX_DEF
`endif
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    logic     if_gnt;
    logic     d_gnt;
    logic     force_if;
    arb_tag_t tag_push;
    arb_tag_t tag_pop;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Saturated counter means fetch has waited long enough.
    assign force_if = (starve_q == CNT_W'(STARVE_MAX));

    always_comb begin
        starve_d = starve_q;
        if (if_gnt) begin
            starve_d = '0;
        end else if (bus.if_req && !force_if) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // Data wins unless the guard forces a contended fetch.
    // Grants are held low during reset.
    always_comb begin
        d_gnt  = bus.d_req & ~(force_if & bus.if_req) & ~reset;
        if_gnt = bus.if_req & ~d_gnt & ~reset;
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_sel   = SEL_INSTR;
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if (d_gnt) begin
            bus.mem_en    = 1'b1;
            bus.mem_sel   = SEL_DATA;
            bus.mem_addr  = IADDR_W'(bus.d_addr);
            bus.mem_we    = bus.d_we;
            bus.mem_wdata = bus.d_wdata;
        end else if (if_gnt) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.if_addr;
        end
    end

    // Stores push an empty slot so the pipe stays aligned
    // with the memory's read latency.
    always_comb begin
        tag_push.valid = if_gnt | (d_gnt & ~bus.d_we);
        tag_push.sel   = d_gnt ? SEL_DATA : SEL_INSTR;
    end

    arb_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (reset),
        .tag_i (tag_push),
        .tag_o (tag_pop)
    );

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = tag_pop.valid & (tag_pop.sel == SEL_INSTR);
    assign bus.d_rvalid  = tag_pop.valid & (tag_pop.sel == SEL_DATA);
    assign bus.if_rdata  = reset ? '0 : bus.mem_rdata;
    assign bus.d_rdata   = reset ? '0 : bus.mem_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: MEM_LAT=1 and MEM_LAT=3 arbiters driven in lockstep,
// each with its own memory model, compared against a transaction-level reference.
module tb_mem_port_arbiter;

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       if_req = 0;
    logic [9:0] if_addr = 0;
    logic       d_req = 0;
    logic       d_we = 0;
    logic [7:0] d_addr = 0;
    logic [7:0] d_wdata = 0;

    mem_port_arbiter_if m1 ();
    mem_port_arbiter_if m3 ();

    assign m1.if_req = if_req;  assign m3.if_req = if_req;
    assign m1.if_addr = if_addr; assign m3.if_addr = if_addr;
    assign m1.d_req = d_req;    assign m3.d_req = d_req;
    assign m1.d_we = d_we;      assign m3.d_we = d_we;
    assign m1.d_addr = d_addr;  assign m3.d_addr = d_addr;
    assign m1.d_wdata = d_wdata; assign m3.d_wdata = d_wdata;

    mem_port_arbiter #(.MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(m1));
    mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(m3));

    // Memory contents: one instruction image, separate data spaces per DUT.
    logic [15:0] imem [1024];
    logic [7:0]  dmem1 [256];
    logic [7:0]  dmem3 [256];
    logic [7:0]  ref_dmem [256];
    logic [15:0] p3 [2];

    always @(posedge clk) begin
        if (m1.mem_en && m1.mem_we) dmem1[m1.mem_addr[7:0]] <= m1.mem_wdata;
        if (m1.mem_en && !m1.mem_we)
            m1.mem_rdata <= m1.mem_sel ? {8'h00, dmem1[m1.mem_addr[7:0]]} : imem[m1.mem_addr];
        else
            m1.mem_rdata <= 16'h0BAD;
    end

    always @(posedge clk) begin
        if (m3.mem_en && m3.mem_we) dmem3[m3.mem_addr[7:0]] <= m3.mem_wdata;
        if (m3.mem_en && !m3.mem_we)
            p3[0] <= m3.mem_sel ? {8'h00, dmem3[m3.mem_addr[7:0]]} : imem[m3.mem_addr];
        else
            p3[0] <= 16'h0BAD;
        p3[1] <= p3[0];
        m3.mem_rdata <= p3[1];
    end

    // Reference model state
    typedef struct {
        int          lat;
        int          due;
        logic        sel;
        logic [15:0] data;
    } rsp_t;

    rsp_t rq[$];
    int   cyc = 0;
    int   cnt = 0;
    int   errors = 0;
    int   checks = 0;
    int   n_if_gnt = 0;
    logic last_if_gnt = 0;
    logic last_d_gnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_port(input int lat, input logic ig, input logic dg,
                              input logic en, input logic sel, input logic [9:0] addr,
                              input logic we, input logic [7:0] wd,
                              input logic eg_if, input logic eg_d);
        logic [9:0] ea;
        ea = eg_d ? {2'b00, d_addr} : (eg_if ? if_addr : 10'd0);
        chk($sformatf("lat%0d if_gnt", lat), ig, eg_if);
        chk($sformatf("lat%0d d_gnt", lat), dg, eg_d);
        chk($sformatf("lat%0d mem_en", lat), en, eg_if | eg_d);
        chk($sformatf("lat%0d mem_sel", lat), sel, eg_d);
        chk($sformatf("lat%0d mem_addr", lat), addr, ea);
        chk($sformatf("lat%0d mem_we", lat), we, eg_d & d_we);
        if (eg_d && d_we) chk($sformatf("lat%0d mem_wdata", lat), wd, d_wdata);
    endtask

    task automatic check_resp(input int lat, input logic ifv, input logic dv,
                              input logic [15:0] ifd, input logic [7:0] dd);
        logic        ev_if;
        logic        ev_d;
        logic [15:0] ed;
        int          hit;
        ev_if = 0; ev_d = 0; ed = '0; hit = -1;
        foreach (rq[i]) if (rq[i].lat == lat && rq[i].due == cyc) hit = i;
        if (hit >= 0) begin
            ev_if = !rq[hit].sel;
            ev_d  = rq[hit].sel;
            ed    = rq[hit].data;
            rq.delete(hit);
        end
        chk($sformatf("lat%0d if_rvalid", lat), ifv, ev_if);
        chk($sformatf("lat%0d d_rvalid", lat), dv, ev_d);
        if (ev_if) chk($sformatf("lat%0d if_rdata", lat), ifd, ed);
        if (ev_d) chk($sformatf("lat%0d d_rdata", lat), dd, ed[7:0]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " lat1 outs"}, {m1.if_gnt, m1.if_rvalid, m1.if_rdata, m1.d_gnt, m1.d_rvalid,
            m1.d_rdata, m1.mem_en, m1.mem_sel, m1.mem_addr, m1.mem_we, m1.mem_wdata}, '0);
        chk({tag, " lat3 outs"}, {m3.if_gnt, m3.if_rvalid, m3.if_rdata, m3.d_gnt, m3.d_rvalid,
            m3.d_rdata, m3.mem_en, m3.mem_sel, m3.mem_addr, m3.mem_we, m3.mem_wdata}, '0);
    endtask

    // One clock cycle: check at negedge, advance the model, step past posedge.
    task automatic cycle();
        logic eg_if;
        logic eg_d;
        logic force_f;
        @(negedge clk);
        force_f = GUARD && (cnt == STARVE_MAX) && if_req;
        eg_d    = d_req && !force_f;
        eg_if   = if_req && !eg_d;
        if (m1.if_gnt) n_if_gnt++;
        check_port(1, m1.if_gnt, m1.d_gnt, m1.mem_en, m1.mem_sel, m1.mem_addr,
                   m1.mem_we, m1.mem_wdata, eg_if, eg_d);
        check_port(3, m3.if_gnt, m3.d_gnt, m3.mem_en, m3.mem_sel, m3.mem_addr,
                   m3.mem_we, m3.mem_wdata, eg_if, eg_d);
        check_resp(1, m1.if_rvalid, m1.d_rvalid, m1.if_rdata, m1.d_rdata);
        check_resp(3, m3.if_rvalid, m3.d_rvalid, m3.if_rdata, m3.d_rdata);
        if (eg_d && d_we) ref_dmem[d_addr] = d_wdata;
        if (eg_d && !d_we) begin
            rq.push_back('{1, cyc + 1, 1'b1, {8'h00, ref_dmem[d_addr]}});
            rq.push_back('{3, cyc + 3, 1'b1, {8'h00, ref_dmem[d_addr]}});
        end
        if (eg_if) begin
            rq.push_back('{1, cyc + 1, 1'b0, imem[if_addr]});
            rq.push_back('{3, cyc + 3, 1'b0, imem[if_addr]});
        end
        if (eg_if) cnt = 0;
        else if (if_req && cnt < STARVE_MAX) cnt++;
        last_if_gnt = eg_if;
        last_d_gnt  = eg_d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) begin
            dmem1[i] = 8'($urandom);
            dmem3[i] = dmem1[i];
            ref_dmem[i] = dmem1[i];
        end

        // Reset state
        if_req = 1; d_req = 1;
        @(negedge clk);
        check_zero("reset_init");
        if_req = 0; d_req = 0;
        @(posedge clk); #1;
        reset = 0;

        // Fetch-only streaming
        for (int a = 0; a < 4; a++) begin
            if_req = 1; if_addr = 10'(a);
            cycle();
        end
        if_req = 0;
        repeat (3) cycle();

        // Contention: load first, then fetch
        if_req = 1; if_addr = 10'h005;
        d_req = 1; d_we = 0; d_addr = 8'h10;
        cycle();
        d_req = 0;
        cycle();
        if_req = 0;
        repeat (3) cycle();

        // Store then load back
        d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'hA5;
        cycle();
        d_we = 0;
        cycle();
        d_req = 0;
        repeat (4) cycle();
        chk("store_readback_ref", {56'd0, dmem1[8'h20]}, 64'hA5);

        // Alternating fetch/load
        for (int i = 0; i < 6; i++) begin
            if_req = (i % 2 == 0);
            d_req  = (i % 2 == 1);
            if_addr = 10'(100 + i);
            d_addr  = 8'(40 + i);
            cycle();
        end
        if_req = 0; d_req = 0;
        repeat (4) cycle();

        // Reset with reads in flight
        if_req = 1; if_addr = 10'h007;
        cycle();
        if_req = 0; d_req = 1; d_we = 0; d_addr = 8'h11;
        cycle();
        if_req = 1; d_req = 1;
        reset = 1;
        #1;
        check_zero("reset_async");
        rq.delete();
        cnt = 0;
        @(posedge clk); #1;
        cyc++;
        check_zero("reset_held");
        if_req = 0; d_req = 0;
        reset = 0;
        repeat (6) cycle();

        // Both held high: starvation behaviour
        n_if_gnt = 0;
        if_req = 1; if_addr = 10'h03F;
        d_req = 1; d_we = 0; d_addr = 8'h30;
        repeat (15) cycle();
        chk("starve_if_gnt_count", n_if_gnt, GUARD ? 3 : 0);
        if_req = 0; d_req = 0;
        repeat (4) cycle();

        // Randomized traffic, requests held until granted
        for (int n = 0; n < 400; n++) begin
            if (!if_req || last_if_gnt || $urandom_range(0, 9) == 0) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = 10'($urandom);
            end
            if (!d_req || last_d_gnt || $urandom_range(0, 9) == 0) begin
                d_req   = ($urandom_range(0, 99) < 50);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = 8'($urandom_range(0, 15));
                d_wdata = 8'($urandom);
            end
            last_if_gnt = 0;
            last_d_gnt  = 0;
            cycle();
        end
        if_req = 0; d_req = 0;
        repeat (5) cycle();
        chk("resp_queue_drained", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
